// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: shared FSM state type and default sizing for the period meter.
package clk_period_meter_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, MEAS} state_t;
  localparam int CNT_W_DEF = 20;
  localparam int MAX_CNT_DEF = 1048575;
endpackage

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: measured signal, enable and measurement results of the period meter.
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             sig_in;
  logic             meas_en;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             timeout_out;
  modport master (output sig_in, meas_en, input period_out, high_out, meas_valid, timeout_out);
  modport slave (input sig_in, meas_en, output period_out, high_out, meas_valid, timeout_out);
endinterface

// File: rtl/clk_period_meter_sig_edge_sync.sv
// sig_edge_sync: 2-flop synchroniser plus edge register giving level, rise and fall of a slow async input.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pre,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= 3'b000;
    else     {s1, s2, s3} <= {d, s1, s2};
  end
  assign pre  = s1;
  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures rise-to-rise period and high time of a slow async wave, with stuck-signal timeout.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_CNT = MAX_CNT_DEF
) (
  input logic clk_in,
  input logic reset,
  clk_period_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, hi_cnt;
  logic pre, lvl, rise, fall, strobe, tmo, at_max;
  sig_edge_sync u_sync (
    .clk(clk_in), .rst(reset), .d(bus.sig_in),
    .pre(pre), .lvl(lvl), .rise(rise), .fall(fall)
  );
  assign at_max = cnt == MAX;
  // WAIT_LOW also looks one stage ahead so the zeroed synchroniser after reset is not taken as a low
  always_comb begin
    state_n = state;
    strobe  = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE:      state_n = WAIT_LOW;
      WAIT_LOW:  state_n = (lvl | pre) ? WAIT_LOW : WAIT_RISE;
      WAIT_RISE: state_n = rise ? MEAS : WAIT_RISE;
      MEAS: begin
        strobe  = rise;
        tmo     = ~rise & at_max;
        state_n = tmo ? WAIT_LOW : MEAS;
      end
      default:   state_n = IDLE;
    endcase
    if (!bus.meas_en) begin
      state_n = IDLE;
      strobe  = 1'b0;
      tmo     = 1'b0;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt             <= '0;
      hi_cnt          <= '0;
      bus.period_out  <= '0;
      bus.high_out    <= '0;
      bus.meas_valid  <= 1'b0;
      bus.timeout_out <= 1'b0;
    end else begin
      bus.meas_valid  <= strobe;
      bus.timeout_out <= tmo | (bus.timeout_out & bus.meas_en & ~strobe);
      if (strobe) begin
        bus.period_out <= cnt;
        bus.high_out   <= hi_cnt;
      end
      if (state_n == MEAS) cnt <= (state != MEAS || rise) ? ONE : (at_max ? cnt : cnt + ONE);
      if (state == MEAS && fall && bus.meas_en) hi_cnt <= cnt;
    end
  end
endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures a slow, asynchronous square wave (e.g. a divided-down tick or clock from another block or a pin) in CLK_IN cycles. Reports the full period (rise to rise) and the high time (rise to fall) of each complete cycle with a one-cycle valid strobe. Flags a timeout when the signal stops toggling. Sits at the receiving end of the clock-divider outputs and is used for self-check and frequency monitoring.

Parameters:
CNT_W, 20, width of the period/high-time counters and outputs.
MAX_CNT, 1048575, timeout threshold in CLK_IN cycles; must be <= 2^CNT_W-1.

Ports:
CLK_IN  input  1  system clock; the only clock.
RESET  input  1  synchronous reset, active-high.
SIG_IN  input  1  asynchronous signal to be measured.
MEAS_EN  input  1  level; 1 = measure, 0 = idle and discard partial results.
PERIOD_OUT  output  CNT_W  last complete period in CLK_IN cycles.
HIGH_OUT  output  CNT_W  high time of the same period in CLK_IN cycles.
MEAS_VALID  output  1  one-cycle strobe; PERIOD_OUT/HIGH_OUT updated on this cycle.
TIMEOUT_OUT  output  1  sticky flag: no edge within MAX_CNT cycles.

Behaviour:
- Reset: synchronous and active-high, sampled on the CLK_IN rising edge. Reset clears PERIOD_OUT=0, HIGH_OUT=0, MEAS_VALID=0, TIMEOUT_OUT=0, the sync flops s1/s2/s3=0, cnt=0 and hi_cnt=0, and puts the FSM in IDLE. Reset mid-measurement aborts it with no strobe.
- Input path: SIG_IN goes through a 2-flop synchroniser (s1, s2) and then s3. rise = s2 & ~s3; fall = ~s2 & s3.
- Latency: a rise of SIG_IN sampled at edge e1 is detected between e2 and e3. MEAS_VALID is high in the cycle following e3.
- FSM states:
  IDLE: MEAS_EN=1 -> WAIT_LOW.
  WAIT_LOW: s2=0 -> WAIT_RISE. This prevents a false first edge when SIG_IN is already high at enable or reset.
  WAIT_RISE: rise -> MEAS with cnt<=1.
  MEAS: described in the counter bullets below.
- In every state, MEAS_EN=0 -> IDLE next cycle. PERIOD_OUT and HIGH_OUT hold their values, and TIMEOUT_OUT clears.
- cnt in MEAS:
  - On a rise cycle: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at MAX_CNT.
  - Result: cnt equals k, k cycles after the starting rise.
- fall in MEAS: hi_cnt<=cnt.
- rise in MEAS: PERIOD_OUT<=cnt, HIGH_OUT<=hi_cnt, MEAS_VALID<=1, TIMEOUT_OUT<=0, cnt<=1, and the FSM stays in MEAS. Measurements are back-to-back, one strobe per period.
- Timeout: in MEAS with cnt==MAX_CNT and no rise that cycle -> TIMEOUT_OUT<=1 and go to WAIT_LOW, with no strobe. Covers SIG_IN stuck high or stuck low.
- Timeout in WAIT_LOW/WAIT_RISE: no timeout; these states wait indefinitely.
- Simultaneous events:
  - MEAS_EN=0 together with rise -> no strobe (MEAS_EN wins).
  - rise together with cnt==MAX_CNT -> valid period of MAX_CNT, no timeout.
- Constraint: SIG_IN high and low phases must each be >= 2 CLK_IN cycles. Shorter phases give undefined values but must never lock up the FSM; timeout or the next rise recovers it.
- MEAS_VALID is high for exactly one cycle per strobe, never two consecutive cycles.
- Ratio check: for a 1,000,000-cycle period at 50% duty, PERIOD_OUT=1000000 and HIGH_OUT=500000.

Decomposition:
- Shared package: state enum {IDLE, WAIT_LOW, WAIT_RISE, MEAS}, default CNT_W, default MAX_CNT.
- Sub-module sig_edge_sync: the 2-flop synchroniser plus edge register, with outputs lvl (s2), rise, fall. It is reset synchronously by RESET and is reusable by other blocks that receive slow clocks.

Test Plan:
- Steady wave: MEAS_EN=1, SIG_IN period 10, high 4 -> first strobe after one full period, then a strobe every 10 cycles with PERIOD_OUT=10, HIGH_OUT=4.
- Frequency change: period 10/high 5 switching to period 24/high 12 -> strobes show 10/5; the transition period gives a consistent value; then 24/12.
- High at enable: SIG_IN already high when RESET deasserts and MEAS_EN=1 -> no strobe until a low then rise are seen; first strobe only after a complete rise-to-rise period.
- Timeout: MAX_CNT=64, SIG_IN stuck low after two good periods -> TIMEOUT_OUT=1 when cnt reaches 64, no strobe. A restarted wave clears TIMEOUT_OUT at the next strobe.
- Abort: MEAS_EN=0 mid-period, including the same cycle as a rise -> no strobe, outputs hold their last values, TIMEOUT_OUT=0. Re-enable -> WAIT_LOW flow resumes.
- Reset mid-measurement: RESET=1 for one cycle -> all outputs 0 on the next cycle, FSM in IDLE, no spurious MEAS_VALID afterwards.
